// File: rtl/map_tile_arbiter_if.sv
// rtl/map_tile_arbiter_if.sv - map RAM arbiter bus: read clients, write client, RAM port
interface map_tile_arbiter_if #(
  parameter int N_REQ  = 5,
  parameter int ADDR_W = 11,
  parameter int TILE_W = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rd_valid;
  logic [TILE_W-1:0]       rd_data;
  logic                    wr_req;
  logic [ADDR_W-1:0]       wr_addr;
  logic [TILE_W-1:0]       wr_data;
  logic                    wr_gnt;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [TILE_W-1:0]       mem_wdata;
  logic [TILE_W-1:0]       mem_rdata;

  modport slave (
    input  req, req_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output gnt, rd_valid, rd_data, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, req_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  gnt, rd_valid, rd_data, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/map_tile_arbiter.sv
// rtl/map_tile_arbiter.sv - round-robin map RAM arbiter, optional stats via MAP_TILE_ARBITER_STATS_EN
module map_tile_arbiter #(
  parameter int N_REQ  = 5,
  parameter int MAP_W  = 32,
  parameter int MAP_H  = 36,
  parameter int TILE_W = 4,
  parameter int ADDR_W = $clog2(MAP_W * MAP_H)
) (
  input  logic              vga_pix_clk,
  input  logic              rst_n,
  map_tile_arbiter_if.slave bus
`ifdef MAP_TILE_ARBITER_STATS_EN
  ,
  output logic [15:0]       grant_cnt,
  output logic [7:0]        max_wait
`endif
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_W * MAP_H - 1);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              last_was_write_q, last_was_write_d;
  logic [N_REQ-1:0]  valid_q, valid_d;
  logic              oob_q, oob_d;

  logic              rd_hit;
  logic [PTR_W-1:0]  hit_idx;
  logic [ADDR_W-1:0] hit_addr;
  logic              rd_oob;
  logic              wr_oob;
  logic [N_REQ-1:0]  gnt;
  logic              wr_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [TILE_W-1:0] mem_wdata;

  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PTR_W'(sum);
  endfunction

  // First requesting index at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    rd_hit  = 1'b0;
    hit_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!rd_hit && bus.req[rr_index(rr_ptr_q, off)]) begin
        rd_hit  = 1'b1;
        hit_idx = rr_index(rr_ptr_q, off);
      end
    end
    hit_addr = bus.req_addr[int'(hit_idx) * ADDR_W +: ADDR_W];
  end

  // Grants, RAM issue (out-of-range accesses consume a slot but leave the RAM idle) and next state
  always_comb begin
    wr_gnt    = rst_n && bus.wr_req && !last_was_write_q;
    gnt       = '0;
    if (rst_n && !wr_gnt && rd_hit) gnt[hit_idx] = 1'b1;
    rd_oob    = hit_addr > LAST_ADDR;
    wr_oob    = bus.wr_addr > LAST_ADDR;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_gnt) begin
      mem_en    = !wr_oob;
      mem_we    = 1'b1;
      mem_addr  = bus.wr_addr;
      mem_wdata = bus.wr_data;
    end else if (|gnt) begin
      mem_en   = !rd_oob;
      mem_addr = hit_addr;
    end
    rr_ptr_d = rr_ptr_q;
    if (|gnt) rr_ptr_d = (hit_idx == PTR_W'(N_REQ - 1)) ? '0 : hit_idx + PTR_W'(1);
    last_was_write_d = wr_gnt;
    valid_d          = gnt;
    oob_d            = (|gnt) && rd_oob;
  end

  // Arbiter state and one-cycle response pipeline; reset drops any in-flight response
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q         <= '0;
      last_was_write_q <= 1'b0;
      valid_q          <= '0;
      oob_q            <= 1'b0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      last_was_write_q <= last_was_write_d;
      valid_q          <= valid_d;
      oob_q            <= oob_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.wr_gnt    = wr_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.rd_valid  = valid_q;
  assign bus.rd_data   = oob_q ? '0 : bus.mem_rdata;

`ifdef MAP_TILE_ARBITER_STATS_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;
  logic [7:0]  max_wait_q, max_wait_d;
  logic [7:0]  wait_q [N_REQ];
  logic [7:0]  wait_d [N_REQ];

  // Saturating grant count and longest unbroken request-without-grant run
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (((|gnt) || wr_gnt) && (grant_cnt_q != 16'hFFFF)) grant_cnt_d = grant_cnt_q + 16'd1;
    max_wait_d = max_wait_q;
    for (int i = 0; i < N_REQ; i++) begin
      wait_d[i] = '0;
      if (bus.req[i] && !gnt[i]) wait_d[i] = (wait_q[i] == 8'hFF) ? wait_q[i] : wait_q[i] + 8'd1;
      if (wait_d[i] > max_wait_d) max_wait_d = wait_d[i];
    end
  end

  // Statistics registers
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      max_wait_q  <= '0;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      max_wait_q  <= max_wait_d;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign max_wait  = max_wait_q;
`endif
endmodule
